// File: rtl/pdp11_mem_arbiter_if.sv
// pdp11_mem_arbiter_if: fetch/data request, byte memory port and trace signals of the memory arbiter
interface pdp11_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int BYTE_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic              if_err;
  logic [WORD_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic              d_sz;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic              d_err;
  logic [WORD_W-1:0] d_rdata;
  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [BYTE_W-1:0] m_wdata;
  logic              m_ready;
  logic [BYTE_W-1:0] m_rdata;
  logic              tr_valid;
  logic [1:0]        tr_type;
  logic [ADDR_W-1:0] tr_addr;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_sz, d_addr, d_wdata, m_ready, m_rdata,
    output if_gnt, if_done, if_err, if_rdata, d_gnt, d_done, d_err, d_rdata,
           m_valid, m_we, m_addr, m_wdata, tr_valid, tr_type, tr_addr
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_sz, d_addr, d_wdata, m_ready, m_rdata,
    input  if_gnt, if_done, if_err, if_rdata, d_gnt, d_done, d_err, d_rdata,
           m_valid, m_we, m_addr, m_wdata, tr_valid, tr_type, tr_addr
  );
endinterface

// File: rtl/pdp11_mem_arbiter.sv
// pdp11_mem_arbiter: shares the byte-wide memory port between fetch and data, splitting words into two beats
module pdp11_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int WORD_W       = 16,
  parameter int BYTE_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int WAIT_TIMEOUT = 256
) (
  input logic clk,
  input logic reset,
  pdp11_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BEAT_LO, BEAT_HI, DONE} state_t;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
  state_t st;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic sel_f, a_we, a_byte, a_err;
  logic [ADDR_W-1:0] a_addr;
  logic [WORD_W-1:0] a_wdata;
  logic [BYTE_W-1:0] lo_byte;
  logic pick_f, pick_d, granted, timeout, fin, fin_err, beat_ok;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] rd_word;
  always_comb begin
    pick_f   = bus.if_req && (!bus.d_req || starve_cnt == STARVE_MAX);
    pick_d   = bus.d_req && !pick_f;
    req_addr = pick_f ? bus.if_addr : bus.d_addr;
    granted  = bus.if_gnt || bus.d_gnt;
    beat_ok  = bus.m_valid && bus.m_ready;
    timeout  = bus.m_valid && !bus.m_ready && wait_cnt == WAIT_LAST;
    // the grant cycle itself still counts as IDLE; the beat or the error finish follows it
    fin      = (st == IDLE && granted && a_err) || (beat_ok && (st == BEAT_HI || a_byte)) || timeout;
    fin_err  = !beat_ok;
    rd_word  = st == BEAT_LO ? {{(WORD_W-BYTE_W){1'b0}}, bus.m_rdata} : {bus.m_rdata, lo_byte};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      starve_cnt <= '0;
      wait_cnt <= '0;
      sel_f <= 1'b0;
      a_we <= 1'b0;
      a_byte <= 1'b0;
      a_err <= 1'b0;
      a_addr <= '0;
      a_wdata <= '0;
      lo_byte <= '0;
      bus.if_gnt <= 1'b0;
      bus.if_done <= 1'b0;
      bus.if_err <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_gnt <= 1'b0;
      bus.d_done <= 1'b0;
      bus.d_err <= 1'b0;
      bus.d_rdata <= '0;
      bus.m_valid <= 1'b0;
      bus.m_we <= 1'b0;
      bus.m_addr <= '0;
      bus.m_wdata <= '0;
      bus.tr_valid <= 1'b0;
      bus.tr_type <= 2'd0;
      bus.tr_addr <= '0;
    end else begin
      bus.if_gnt <= 1'b0;
      bus.d_gnt <= 1'b0;
      bus.tr_valid <= 1'b0;
      bus.if_done <= fin && sel_f;
      bus.d_done <= fin && !sel_f;
      bus.if_err <= fin && fin_err && sel_f;
      bus.d_err <= fin && fin_err && !sel_f;
      case (st)
        IDLE: if (granted) begin
          wait_cnt <= '0;
          if (!a_err) begin
            st <= BEAT_LO;
            bus.m_valid <= 1'b1;
            bus.m_we <= a_we;
            bus.m_addr <= a_addr;
            bus.m_wdata <= a_wdata[BYTE_W-1:0];
          end
        end else if (pick_f || pick_d) begin
          bus.if_gnt <= pick_f;
          bus.d_gnt <= pick_d;
          bus.tr_valid <= 1'b1;
          bus.tr_type <= pick_f ? 2'd2 : {1'b0, bus.d_we};
          bus.tr_addr <= req_addr;
          sel_f <= pick_f;
          a_addr <= req_addr;
          a_we <= pick_d && bus.d_we;
          a_byte <= pick_d && bus.d_sz;
          a_wdata <= bus.d_wdata;
          a_err <= (pick_f || !bus.d_sz) && req_addr[0];
          starve_cnt <= (pick_d && bus.if_req) ? starve_cnt + 1'b1 : '0;
        end
        BEAT_LO, BEAT_HI: if (beat_ok && st == BEAT_LO && !a_byte) begin
          st <= BEAT_HI;
          wait_cnt <= '0;
          lo_byte <= bus.m_rdata;
          bus.m_addr <= {a_addr[ADDR_W-1:1], 1'b1};
          bus.m_wdata <= a_wdata[WORD_W-1:BYTE_W];
        end else if (!bus.m_ready && !timeout) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        DONE: st <= IDLE;
      endcase
      if (fin) begin
        st <= DONE;
        bus.m_valid <= 1'b0;
        if (beat_ok && !a_we && sel_f) bus.if_rdata <= rd_word;
        if (beat_ok && !a_we && !sel_f) bus.d_rdata <= rd_word;
      end
    end
  end
endmodule

// File: tb/tb_pdp11_mem_arbiter.sv
// tb_pdp11_mem_arbiter: scoreboard bench driving fetch/data requests against a byte memory model
module tb_pdp11_mem_arbiter;
  typedef struct {
    bit f;
    bit err;
    bit rd_chk;
    logic [15:0] rdata;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ready_en = 1'b1;
  logic bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  logic [7:0] mem [0:65535];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int viol = 0;
  exp_t sb[$];
  logic [24:0] eb[$];
  logic [24:0] ob[$];
  bit o_to, o_f, o_done_f, o_err, o_trv;
  logic [15:0] o_rdata, o_tr_addr;
  logic [1:0] o_tr_type;
  int o_lat, o_mv;
  logic [82:0] outs;

  pdp11_mem_arbiter_if bus ();
  pdp11_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.m_ready = ready_en;
  assign bus.m_rdata = mem[bus.m_addr];
  assign outs = {bus.if_gnt, bus.if_done, bus.if_err, bus.if_rdata, bus.d_gnt, bus.d_done, bus.d_err,
                 bus.d_rdata, bus.m_valid, bus.m_we, bus.m_addr, bus.m_wdata, bus.tr_valid, bus.tr_type, bus.tr_addr};

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.m_valid && bus.m_ready && bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit beats_match();
    if (ob.size() != eb.size()) return 1'b0;
    foreach (ob[i]) if (ob[i] !== eb[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_txn(input bit f, input bit we, input bit sz, input logic [15:0] addr,
                         input logic [15:0] wdata, input int budget);
    int g;
    g = 0;
    o_to = 1'b1;
    o_mv = 0;
    o_lat = -1;
    ob.delete();
    @(negedge clk);
    if (f) begin
      bus.if_req = 1'b1;
      bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1;
      bus.d_we = we;
      bus.d_sz = sz;
      bus.d_addr = addr;
      bus.d_wdata = wdata;
    end
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      viol += int'((bus.if_gnt && bus.d_gnt) || (bus.if_done && bus.d_done) ||
                   (bus.m_valid && (bus.if_gnt || bus.d_gnt || bus.if_done || bus.d_done)));
      if (bus.m_valid) o_mv++;
      if (bus.m_valid && bus.m_ready) ob.push_back({bus.m_we, bus.m_addr, bus.m_we ? bus.m_wdata : bus.m_rdata});
      if (bus.if_gnt || bus.d_gnt) begin
        g = cyc;
        o_f = bus.if_gnt;
        o_trv = bus.tr_valid;
        o_tr_type = bus.tr_type;
        o_tr_addr = bus.tr_addr;
      end
      if (bus.if_done || bus.d_done) begin
        o_to = 1'b0;
        o_lat = cyc - g;
        o_done_f = bus.if_done;
        o_err = bus.if_err || bus.d_err;
        o_rdata = bus.if_done ? bus.if_rdata : bus.d_rdata;
        break;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_addr = 16'o1000;
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    @(negedge clk);
    checks++;
    if (bus.if_gnt !== 1'b0 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold if_gnt=%b m_valid=%b want 0 0", bus.if_gnt, bus.m_valid);
    end
    bus.if_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    poke(16'o1000, 8'h34);
    poke(16'o1001, 8'h12);
    sb.push_back('{f: 1'b1, err: 1'b0, rd_chk: 1'b1, rdata: 16'h1234, lat: 3});
    eb.delete();
    eb.push_back({1'b0, 16'h0200, 8'h34});
    eb.push_back({1'b0, 16'h0201, 8'h12});
    run_txn(1'b1, 1'b0, 1'b0, 16'o1000, 16'h0, 20);
    e = sb.pop_front();
    checks++;
    if (o_to || o_lat != e.lat || o_f != e.f || o_done_f != e.f) begin
      failures++;
      $display("FAIL fetch_done lat=%0d want=%0d fetch=%b timeout=%b", o_lat, e.lat, o_done_f, o_to);
    end
    checks++;
    if (o_err !== e.err || o_rdata !== e.rdata) begin
      failures++;
      $display("FAIL fetch_data err=%b rdata=%h want err=%b rdata=%h", o_err, o_rdata, e.err, e.rdata);
    end
    checks++;
    if (!o_trv || o_tr_type !== 2'd2 || o_tr_addr !== 16'o1000) begin
      failures++;
      $display("FAIL fetch_trace valid=%b type=%0d addr=%h want 1 2 0200", o_trv, o_tr_type, o_tr_addr);
    end
    checks++;
    if (!beats_match()) begin
      failures++;
      $display("FAIL fetch_beats got=%0d beats want=%0d", ob.size(), eb.size());
    end
  endtask

  task automatic test_write();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{f: 1'b0, err: 1'b0, rd_chk: i == 1, rdata: 16'hBEEF, lat: 3});
      eb.delete();
      eb.push_back({i == 0, 16'h0100, 8'hEF});
      eb.push_back({i == 0, 16'h0101, 8'hBE});
      run_txn(1'b0, i == 0, 1'b0, 16'h0100, 16'hBEEF, 20);
      e = sb.pop_front();
      checks++;
      if (o_to || o_lat != e.lat || o_done_f != e.f) begin
        failures++;
        $display("FAIL word_%0d_done lat=%0d want=%0d timeout=%b", i, o_lat, e.lat, o_to);
      end
      checks++;
      if (o_err !== e.err || (e.rd_chk && o_rdata !== e.rdata) || o_tr_type !== 2'(1 - i)) begin
        failures++;
        $display("FAIL word_%0d_result err=%b rdata=%h type=%0d want err=0 rdata=%h type=%0d",
                 i, o_err, o_rdata, o_tr_type, e.rdata, 1 - i);
      end
      checks++;
      if (!beats_match()) begin
        failures++;
        $display("FAIL word_%0d_beats got=%0d first=%h want=%0d first=%h", i, ob.size(), ob[0], eb.size(), eb[0]);
      end
    end
  endtask

  task automatic test_byte();
    exp_t e;
    poke(16'h0103, 8'h80);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{f: 1'b0, err: 1'b0, rd_chk: i == 0, rdata: 16'h0080, lat: 2});
      eb.delete();
      eb.push_back(i == 0 ? {1'b0, 16'h0103, 8'h80} : {1'b1, 16'h0105, 8'h34});
      run_txn(1'b0, i == 1, 1'b1, i == 0 ? 16'h0103 : 16'h0105, 16'h1234, 20);
      e = sb.pop_front();
      checks++;
      if (o_to || o_lat != e.lat || o_err !== e.err || (e.rd_chk && o_rdata !== e.rdata)) begin
        failures++;
        $display("FAIL byte_%0d lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=%h", i, o_lat, o_err, o_rdata, e.lat, e.rdata);
      end
      checks++;
      if (!beats_match()) begin
        failures++;
        $display("FAIL byte_%0d_beats got=%0d first=%h want=%0d first=%h", i, ob.size(), ob[0], eb.size(), eb[0]);
      end
    end
  endtask

  task automatic test_align();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{f: i == 1, err: 1'b1, rd_chk: 1'b0, rdata: 16'h0, lat: 1});
      run_txn(i == 1, 1'b0, 1'b0, i == 0 ? 16'h0101 : 16'h0201, 16'h0, 20);
      e = sb.pop_front();
      checks++;
      if (o_to || o_lat != e.lat || o_done_f != e.f || o_err !== e.err || o_mv != 0) begin
        failures++;
        $display("FAIL align_%0d lat=%0d fetch=%b err=%b mvalid_cycles=%0d want lat=1 fetch=%b err=1 mvalid_cycles=0",
                 i, o_lat, o_done_f, o_err, o_mv, e.f);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    ready_en = 1'b0;
    sb.push_back('{f: 1'b0, err: 1'b1, rd_chk: 1'b0, rdata: 16'h0, lat: 257});
    run_txn(1'b0, 1'b0, 1'b0, 16'h0500, 16'h0, 400);
    e = sb.pop_front();
    ready_en = 1'b1;
    checks++;
    if (o_to || o_lat != e.lat || o_err !== e.err) begin
      failures++;
      $display("FAIL timeout_done lat=%0d err=%b timeout=%b want lat=%0d err=1", o_lat, o_err, o_to, e.lat);
    end
    checks++;
    if (o_mv != 256) begin
      failures++;
      $display("FAIL timeout_wait mvalid_cycles=%0d want=256", o_mv);
    end
  endtask

  task automatic test_starve();
    bit want[$];
    bit got[$];
    do_reset();
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_addr = 16'h0300;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_sz = 1'b0;
    bus.d_addr = 16'h0400;
    for (int i = 0; i < 6; i++) want.push_back(i == 4);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      viol += int'((bus.if_gnt && bus.d_gnt) || (bus.if_done && bus.d_done));
      if (bus.if_gnt || bus.d_gnt) got.push_back(bus.if_gnt);
      if (got.size() == 6 && (bus.if_done || bus.d_done)) break;
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    checks++;
    if (got.size() != 6) begin
      failures++;
      $display("FAIL starve_grants got=%0d want=6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        failures++;
        $display("FAIL starve_order_%0d fetch=%b want=%b", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    ready_en = 1'b0;
    @(negedge clk);
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_sz = 1'b0;
    bus.d_addr = 16'h0600;
    for (int n = 0; n < 20 && !(bus.m_valid && !bus.m_addr[0]); n++) @(negedge clk);
    ready_en = 1'b1;
    @(negedge clk);
    ready_en = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 16'h0601) begin
      failures++;
      $display("FAIL reset_mid_hi_beat m_valid=%b m_addr=%h want 1 0601", bus.m_valid, bus.m_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h want=0", outs);
    end
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ready_en = 1'b1;
    sb.push_back('{f: 1'b1, err: 1'b0, rd_chk: 1'b1, rdata: 16'h1234, lat: 3});
    run_txn(1'b1, 1'b0, 1'b0, 16'o1000, 16'h0, 20);
    e = sb.pop_front();
    checks++;
    if (o_to || o_lat != e.lat || o_rdata !== e.rdata || o_err !== e.err) begin
      failures++;
      $display("FAIL reset_mid_recover lat=%0d rdata=%h err=%b want lat=3 rdata=%h err=0", o_lat, o_rdata, o_err, e.rdata);
    end
  endtask

  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_sz = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    #2;
    test_reset();
    test_fetch();
    test_write();
    test_byte();
    test_align();
    test_timeout();
    test_starve();
    test_reset_mid();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL exclusive_outputs violations=%0d want=0", viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
